countdown_timer_k: RTL and testbench
====================================

Name: countdown_timer_k

Overview:
Loadable modulo-M down-counter/timer. It is the counting-down counterpart of the team's modulo-K up-counter. It is started with a value, decrements on each qualified tick until it reaches zero, then emits a one-cycle done pulse. The tick input is normally driven by an upstream up-counter's rollover, which acts as a prescaler. It sits beside the up-counter on the board top level, with Q on LEDs and done on a status LED.

Parameters:
M, 20, modulus; legal count range is 0..M-1 (M >= 2).
N, clogb2(M-1), derived localparam (not overridable); width of Q and load_val (5 for M=20).

Ports:
clk  input  1  clock; all state changes on rising edge.
aclr  input  1  reset, asynchronous, active-low.
start  input  1  level sampled each clk; when 1, loads load_val and enters RUN; highest priority after aclr.
stop  input  1  abort: Q<=0, enter IDLE, no done pulse.
pause  input  1  when 1, ticks are ignored; Q holds.
tick  input  1  count strobe; one decrement per clk cycle in which tick=1.
load_val  input  N  start value; clamped to M-1.
Q  output  N  current count (registered).
busy  output  1  1 while state==RUN (registered-state decode).
done  output  1  1 for exactly one cycle while state==EXPIRE.
zero  output  1  combinational (Q==0).

Behaviour:
- Reset (aclr=0, asynchronous, immediate):
  - Q=0, state=IDLE, busy=0, done=0, zero=1.
  - Applies mid-RUN or mid-EXPIRE; no pending done survives reset.
- Registered state: 2-bit FSM with states IDLE, RUN, EXPIRE.
- Priority per edge: start > stop > tick/pause.
- start (any state):
  - Loads v = min(load_val, M-1).
  - If v != 0: Q<=v, next RUN.
  - If v == 0: Q<=0, next EXPIRE.
  - start during RUN restarts with no done pulse.
  - start while in EXPIRE: done is still 1 during that EXPIRE cycle; the new load takes effect at the same edge.
- stop (no start): Q<=0, next IDLE from any state. A done already asserted in the current EXPIRE cycle is not retracted.
- IDLE: Q holds its value; tick and pause are ignored.
- RUN, tick=1 and pause=0:
  - If Q==1: Q<=0, next EXPIRE.
  - Otherwise: Q<=Q-1.
- RUN, otherwise: Q holds.
- Latency: from the start edge with v=K, done is high in the cycle after the K-th qualified tick edge.
- EXPIRE: lasts exactly one cycle; Q=0, done=1, busy=0; next IDLE, unless start is asserted or the optional feature reloads.
- Arithmetic:
  - Comparisons are unsigned, N-bit.
  - The clamp compares load_val as unsigned against M-1.
  - Q never underflows; the 0 -> M-1 wrap is not possible in this block.
- tick held high continuously: one decrement per cycle.
- tick coincident with start: the tick is consumed by the load and does not decrement.

Optional Feature:
COUNTDOWN_AUTO_RELOAD_EN
- Defined:
  - An N-bit reload register captures the clamped v on every start and is cleared to 0 by aclr.
  - In EXPIRE with no start or stop: if reload != 0, Q<=reload and next RUN (periodic timer, period = reload ticks plus 1 cycle); if reload == 0, next IDLE.
  - done still pulses one cycle per expiry.
  - stop halts periodic operation.
- Undefined: the reload register is absent, and EXPIRE always goes to IDLE (one-shot).

Test Plan:
1. Reset: with M=20, start load_val=8, run 3 ticks (Q=5), pulse aclr=0 between edges -> Q=0, busy=0, done=0 immediately, with no clock needed; state stays IDLE after release.
2. One-shot: start with load_val=3, tick=1 every cycle -> Q=3,2,1,0 on successive edges; busy=1 for 3 cycles; done=1 for exactly 1 cycle; then IDLE; zero=1.
3. Clamp/zero load: load_val=25 -> Q=19, done after 19 ticks. load_val=0 -> next cycle EXPIRE, done=1, busy never 1.
4. Pause/restart: load 10, tick every cycle, pause=1 for 5 cycles at Q=6 -> Q stays 6; then start with load_val=4 at Q=5 -> Q=4, no done pulse; done follows 4 ticks later.
5. Stop/simultaneity: stop at Q=2 -> Q=0, IDLE, no done. start and stop together with load 7 -> Q=7, RUN. tick and start together -> Q equals the loaded value, not value-1.
6. COUNTDOWN_AUTO_RELOAD_EN defined: load 2 with continuous ticks -> done every 3 cycles (Q=2,1,0 repeating); stop ends the sequence; undefined -> single done, then IDLE.

Source files
------------

// File: rtl/countdown_timer_k.sv
// Loadable modulo-M down-counter with one-cycle done pulse on expiry.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last start value on expiry (periodic timer).
module countdown_timer_k #(
  parameter int M = 20
) (
  input  logic                        clk,
  input  logic                        aclr,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        pause,
  input  logic                        tick,
  input  logic [((M > 2) ? $clog2(M) : 1)-1:0] load_val,
  output logic [((M > 2) ? $clog2(M) : 1)-1:0] Q,
  output logic                        busy,
  output logic                        done,
  output logic                        zero
);
  localparam int N = (M > 2) ? $clog2(M) : 1;
  localparam logic [N-1:0] MAX = N'(M - 1);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRE} state_t;

  state_t      state, state_n;
  logic [N-1:0] q_n, ld_v;

  assign ld_v = (load_val > MAX) ? MAX : load_val;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [N-1:0] reload;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)      reload <= '0;
    else if (start) reload <= ld_v;
  end
`endif

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state <= IDLE;
      Q     <= '0;
    end else begin
      state <= state_n;
      Q     <= q_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = Q;
    if (start) begin
      // a tick on the same edge is absorbed by the load
      q_n     = ld_v;
      state_n = (ld_v != '0) ? RUN : EXPIRE;
    end else if (stop) begin
      q_n     = '0;
      state_n = IDLE;
    end else begin
      case (state)
        RUN: begin
          if (tick && !pause) begin
            if (Q <= ONE) begin
              q_n     = '0;
              state_n = EXPIRE;
            end else begin
              q_n = Q - ONE;
            end
          end
        end
        EXPIRE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (reload != '0) begin
            q_n     = reload;
            state_n = RUN;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == EXPIRE);
  assign zero = (Q == '0);
endmodule

// File: tb/tb_countdown_timer_k.sv
// Scoreboard bench for countdown_timer_k: stimulus pushes expected post-edge outputs, a monitor pops and compares.
module tb_countdown_timer_k;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, tick = 1'b0;
  logic [4:0] load_val = '0;
  logic [4:0] Q;
  logic       busy, done, zero;

  typedef struct {
    int         id;
    logic [4:0] q;
    logic       busy;
    logic       done;
    logic       zero;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step_id = 0;

  countdown_timer_k #(.M(20)) dut (
    .clk(clk), .aclr(aclr), .start(start), .stop(stop), .pause(pause),
    .tick(tick), .load_val(load_val), .Q(Q), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int id, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", name, id, act, req);
    end
  endtask

  // monitor: outputs are compared 1ns after every rising edge that has a pending expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("q",    e.id, Q,            e.q);
        cmp("busy", e.id, {4'b0, busy}, {4'b0, e.busy});
        cmp("done", e.id, {4'b0, done}, {4'b0, e.done});
        cmp("zero", e.id, {4'b0, zero}, {4'b0, e.zero});
      end
    end
  end

  task automatic step(input logic st, input logic sp, input logic pa, input logic tk,
                      input logic [4:0] lv, input logic [4:0] eq, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    start = st; stop = sp; pause = pa; tick = tk; load_val = lv;
    step_id++;
    e.id = step_id; e.q = eq; e.busy = eb; e.done = ed; e.zero = (eq == 5'd0);
    sb.push_back(e);
  endtask

  task automatic idle(input logic [4:0] eq, input logic eb, input logic ed);
    step(0, 0, 0, 0, 5'd0, eq, eb, ed);
  endtask

  task automatic tk(input logic [4:0] eq, input logic eb, input logic ed);
    step(0, 0, 0, 1, 5'd0, eq, eb, ed);
  endtask

  initial begin
    int wait_cyc;
    #12 aclr = 1'b1;

    // 1: asynchronous reset mid-run
    step(1, 0, 0, 0, 5'd8, 5'd8, 1, 0);
    tk(5'd7, 1, 0); tk(5'd6, 1, 0); tk(5'd5, 1, 0);
    @(posedge clk); #3;
    aclr = 1'b0;
    #1;
    cmp("rst_q",    -1, Q,            5'd0);
    cmp("rst_busy", -1, {4'b0, busy}, 5'd0);
    cmp("rst_done", -1, {4'b0, done}, 5'd0);
    cmp("rst_zero", -1, {4'b0, zero}, 5'd1);
    #2 aclr = 1'b1;
    tk(5'd0, 0, 0);

    // 2: one-shot from 3 with continuous tick
    step(1, 0, 0, 1, 5'd3, 5'd3, 1, 0);
    tk(5'd2, 1, 0); tk(5'd1, 1, 0); tk(5'd0, 0, 1);
    tk(AR ? 5'd3 : 5'd0, AR, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 0, 0);

    // 3: clamp 25 -> 19, then zero load
    step(1, 0, 0, 0, 5'd25, 5'd19, 1, 0);
    for (int i = 18; i >= 1; i--) tk(5'(i), 1, 0);
    tk(5'd0, 0, 1);
    idle(AR ? 5'd19 : 5'd0, AR, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 0, 0);
    step(1, 0, 0, 0, 5'd0, 5'd0, 0, 1);
    idle(5'd0, 0, 0);
    idle(5'd0, 0, 0);

    // 4: pause hold, restart without done
    step(1, 0, 0, 0, 5'd10, 5'd10, 1, 0);
    tk(5'd9, 1, 0); tk(5'd8, 1, 0); tk(5'd7, 1, 0); tk(5'd6, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 5'd0, 5'd6, 1, 0);
    tk(5'd5, 1, 0);
    step(1, 0, 0, 1, 5'd4, 5'd4, 1, 0);
    tk(5'd3, 1, 0); tk(5'd2, 1, 0); tk(5'd1, 1, 0); tk(5'd0, 0, 1);
    idle(AR ? 5'd4 : 5'd0, AR, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 0, 0);

    // 5: stop, start+stop, start+tick, start during EXPIRE
    step(1, 0, 0, 0, 5'd5, 5'd5, 1, 0);
    tk(5'd4, 1, 0); tk(5'd3, 1, 0); tk(5'd2, 1, 0);
    step(0, 1, 0, 1, 5'd0, 5'd0, 0, 0);
    idle(5'd0, 0, 0);
    step(1, 1, 0, 0, 5'd7, 5'd7, 1, 0);
    step(1, 0, 0, 1, 5'd9, 5'd9, 1, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 0, 0);
    step(1, 0, 0, 0, 5'd1, 5'd1, 1, 0);
    tk(5'd0, 0, 1);
    step(1, 0, 0, 1, 5'd3, 5'd3, 1, 0);
    tk(5'd2, 1, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 0, 0);

    // 6: periodic reload (feature build) or single shot
    step(1, 0, 0, 1, 5'd2, 5'd2, 1, 0);
    tk(5'd1, 1, 0); tk(5'd0, 0, 1);
    tk(AR ? 5'd2 : 5'd0, AR, 0);
    tk(AR ? 5'd1 : 5'd0, AR, 0);
    tk(5'd0, 0, AR);
    tk(AR ? 5'd2 : 5'd0, AR, 0);
    step(0, 1, 0, 1, 5'd0, 5'd0, 0, 0);
    tk(5'd0, 0, 0);
    idle(5'd0, 0, 0);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
